// File: rtl/mmio_io_hub_pkg.sv
// Shared constants for the MMIO hub: I/O region tag, register offsets and
// KB_STAT / CTRL bit positions.
package mmio_pkg;

  localparam logic [1:0] IO_TAG_DEF      = 2'b11;

  localparam logic [3:0] OFF_KB_DATA     = 4'h8;
  localparam logic [3:0] OFF_KB_STAT     = 4'h9;
  localparam logic [3:0] OFF_CTRL        = 4'hA;

  localparam int         STAT_OVF_BIT    = 15;
  localparam int         STAT_FULL_BIT   = 14;
  localparam int         STAT_EMPTY_BIT  = 13;
  localparam int         STAT_CNT_W      = 5;

  localparam int         CTRL_IRQ_EN_BIT = 0;

endpackage

// File: rtl/mmio_io_hub_kb_fifo.sv
// Scancode FIFO with occupancy count, full/empty flags and a sticky overflow
// flag. A push into a full FIFO is accepted only when a pop frees a slot in
// the same cycle.
module kb_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  input  logic                       ovf_clr,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign overflow = ovf_q;
  assign dout     = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    ovf_d    = ovf_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (ovf_clr) ovf_d = 1'b0;
    // a dropped code beats a simultaneous clear
    if (push && full && !do_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_io_hub.sv
// Memory-mapped I/O hub: decodes the I/O region, holds output registers and
// CTRL, fronts the scancode FIFO and muxes I/O read data over BRAM data.
module mmio_io_hub
  import mmio_pkg::*;
#(
  parameter int         WIDTH      = 16,
  parameter int         NUM_OUT    = 2,
  parameter int         OUT_W      = 8,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [1:0] IO_TAG     = IO_TAG_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         addr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     we,
  input  logic                     re,
  input  logic [WIDTH-1:0]         mem_q,
  output logic [WIDTH-1:0]         rdata,
  input  logic [7:0]               kb_code,
  input  logic                     kb_valid,
  output logic [NUM_OUT*OUT_W-1:0] out_ports,
  output logic                     kb_irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             io;
  logic [3:0]       offset;
  logic             wr_en;
  logic             kb_pop;
  logic             ovf_clr;
  logic             irq_en_q;
  logic [7:0]       kb_dout;
  logic [7:0]       kb_head;
  logic [CNT_W-1:0] kb_count;
  logic             kb_full, kb_empty, kb_ovf;
  logic [15:0]      kb_stat;
  logic [WIDTH-1:0] io_rdata;
  logic             unused_bits;

  assign io      = (addr[15:14] == IO_TAG);
  assign offset  = addr[3:0];
  assign wr_en   = we & io;
  assign kb_pop  = re & io & (offset == OFF_KB_DATA);
  assign ovf_clr = wr_en & (offset == OFF_KB_STAT);
  // addr[13:4] aliases inside the region; wdata is only partly stored
  assign unused_bits = ^{addr, wdata};

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    logic [OUT_W-1:0] out_q;
    always_ff @(posedge clk) begin
      if (!reset) out_q <= '0;
      else if (wr_en && offset == 4'(g)) out_q <= wdata[OUT_W-1:0];
    end
    assign out_ports[g*OUT_W +: OUT_W] = out_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) irq_en_q <= 1'b0;
    else if (wr_en && offset == OFF_CTRL) irq_en_q <= wdata[CTRL_IRQ_EN_BIT];
  end

  kb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_kb_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (kb_valid),
    .din      (kb_code),
    .pop      (kb_pop),
    .ovf_clr  (ovf_clr),
    .dout     (kb_dout),
    .count    (kb_count),
    .full     (kb_full),
    .empty    (kb_empty),
    .overflow (kb_ovf)
  );

  assign kb_head = kb_empty ? 8'h00 : kb_dout;
  assign kb_irq  = ~kb_empty & irq_en_q;

  always_comb begin
    kb_stat                 = '0;
    kb_stat[STAT_OVF_BIT]   = kb_ovf;
    kb_stat[STAT_FULL_BIT]  = kb_full;
    kb_stat[STAT_EMPTY_BIT] = kb_empty;
    kb_stat[STAT_CNT_W-1:0] = STAT_CNT_W'(kb_count);
  end

  always_comb begin
    io_rdata = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (offset == 4'(i)) io_rdata = WIDTH'(out_ports[i*OUT_W +: OUT_W]);
    end
    case (offset)
      OFF_KB_DATA: io_rdata = WIDTH'(kb_head);
      OFF_KB_STAT: io_rdata = WIDTH'(kb_stat);
      OFF_CTRL:    io_rdata = WIDTH'(irq_en_q);
      default:     ;
    endcase
  end

  assign rdata = io ? io_rdata : mem_q;

endmodule

// File: tb/tb_mmio_io_hub.sv
// Directed bench for mmio_io_hub: stimulus queues expected values, a negedge
// monitor pops and compares them against rdata, out_ports or kb_irq.
module tb_mmio_io_hub;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr, wdata, mem_q, rdata;
  logic        we, re, kb_valid, kb_irq;
  logic [7:0]  kb_code;
  logic [15:0] out_ports;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] exp;
    int          id;
  } exp_t;

  exp_t        sb[$];
  logic        chk_v;
  int          next_id = 0;
  int          checks  = 0;
  int          errors  = 0;

  always #5 clk = ~clk;

  mmio_io_hub dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .re        (re),
    .mem_q     (mem_q),
    .rdata     (rdata),
    .kb_code   (kb_code),
    .kb_valid  (kb_valid),
    .out_ports (out_ports),
    .kb_irq    (kb_irq)
  );

  always @(negedge clk) begin
    if (chk_v) begin
      exp_t        e;
      logic [15:0] act;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: monitor strobe with no expected value queued");
      end else begin
        e = sb.pop_front();
        case (e.sel)
          2'd0:    act = rdata;
          2'd1:    act = out_ports;
          default: act = {15'h0, kb_irq};
        endcase
        if (act !== e.exp) begin
          errors++;
          $display("FAIL check#%0d %s: got %h expected %h", e.id,
                   (e.sel == 2'd0) ? "rdata" : (e.sel == 2'd1) ? "out_ports" : "kb_irq",
                   act, e.exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step_clear();
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; kb_valid = 1'b0; chk_v = 1'b0; reset = 1'b1;
  endtask

  task automatic expect_val(input logic [1:0] sel, input logic [15:0] e);
    sb.push_back('{sel: sel, exp: e, id: next_id});
    next_id++;
    chk_v = 1'b1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr = a; wdata = d; we = 1'b1;
    step_clear();
  endtask

  task automatic push_code(input logic [7:0] c);
    kb_code = c; kb_valid = 1'b1;
    step_clear();
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] e);
    addr = a; re = 1'b1;
    expect_val(2'd0, e);
    step_clear();
  endtask

  task automatic push_pop(input logic [7:0] c, input logic [15:0] e);
    kb_code = c; kb_valid = 1'b1; addr = 16'hC008; re = 1'b1;
    expect_val(2'd0, e);
    step_clear();
  endtask

  task automatic push_clr(input logic [7:0] c);
    kb_code = c; kb_valid = 1'b1; addr = 16'hC009; wdata = 16'h0; we = 1'b1;
    step_clear();
  endtask

  task automatic chk_out(input logic [15:0] e);
    expect_val(2'd1, e);
    step_clear();
  endtask

  task automatic chk_irq(input logic e);
    expect_val(2'd2, {15'h0, e});
    step_clear();
  endtask

  task automatic do_reset();
    reset = 1'b0; kb_valid = 1'b1; kb_code = 8'hAA;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; kb_valid = 1'b0; chk_v = 1'b0; reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
    kb_valid = 1'b0; kb_code = '0; mem_q = 16'hBEEF; chk_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // reset state
    chk_out(16'h0000);
    rd(16'hC009, 16'h2000);
    chk_irq(1'b0);

    // output registers
    wr(16'hC000, 16'h00A5);
    wr(16'hC001, 16'h003C);
    chk_out(16'h3CA5);
    rd(16'hC001, 16'h003C);
    wr(16'hC000, 16'h12A5);
    rd(16'hC000, 16'h00A5);
    rd(16'hC3F1, 16'h003C);
    wr(16'hC005, 16'h1234);
    rd(16'hC005, 16'h0000);
    rd(16'hC00B, 16'h0000);
    chk_out(16'h3CA5);

    // BRAM pass-through
    rd(16'h0123, 16'hBEEF);
    mem_q = 16'h5A5A;
    rd(16'h8008, 16'h5A5A);

    // basic push / pop
    push_code(8'h1C);
    push_code(8'h32);
    rd(16'hC009, 16'h0002);
    rd(16'hC008, 16'h001C);
    rd(16'hC008, 16'h0032);
    rd(16'hC008, 16'h0000);
    rd(16'hC009, 16'h2000);

    // overflow
    for (int i = 0; i < 9; i++) push_code(8'h10 + 8'(i));
    rd(16'hC009, 16'hC008);
    wr(16'hC009, 16'h0000);
    rd(16'hC009, 16'h4008);
    for (int i = 0; i < 8; i++) rd(16'hC008, 16'h0010 + 16'(i));
    rd(16'hC009, 16'h2000);

    // full with simultaneous push and pop
    for (int i = 0; i < 8; i++) push_code(8'h20 + 8'(i));
    push_pop(8'h77, 16'h0020);
    rd(16'hC009, 16'h4008);
    for (int i = 1; i < 8; i++) rd(16'hC008, 16'h0020 + 16'(i));
    rd(16'hC008, 16'h0077);
    rd(16'hC009, 16'h2000);

    // empty with simultaneous push and pop
    push_pop(8'h55, 16'h0000);
    rd(16'hC009, 16'h0001);
    rd(16'hC008, 16'h0055);

    // interrupt level
    wr(16'hC00A, 16'hFFFF);
    rd(16'hC00A, 16'h0001);
    chk_irq(1'b0);
    push_code(8'h42);
    chk_irq(1'b1);
    rd(16'hC008, 16'h0042);
    chk_irq(1'b0);
    push_code(8'h43);
    wr(16'hC00A, 16'h0000);
    chk_irq(1'b0);
    rd(16'hC009, 16'h0001);

    // reset mid-operation
    wr(16'hC00A, 16'h0001);
    do_reset();
    rd(16'hC009, 16'h2000);
    chk_out(16'h0000);
    rd(16'hC00A, 16'h0000);
    chk_irq(1'b0);

    // overflow set and clear on the same edge
    for (int i = 0; i < 8; i++) push_code(8'h60 + 8'(i));
    push_clr(8'h99);
    rd(16'hC009, 16'hC008);
    rd(16'hC008, 16'h0060);

    step_clear();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected values left, 0 required", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
